// File: rtl/inst_loader.sv
// Boot-time program loader: streams 16-bit instruction words from a host into
// instruction memory and holds the CPU in reset until the image is complete.
module inst_loader #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          MAX_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] word_count,
    input  logic        abort,
    input  logic        s_valid,
    input  logic [15:0] s_data,
    output logic        s_ready,
    output logic        im_we,
    output logic [15:0] im_addr,
    output logic [15:0] im_wdata,
    output logic        cpu_hold,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [15:0] checksum
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        FLUSH = 3'd2,
        DONE  = 3'd3,
        ERR   = 3'd4
    } state_t;

    localparam logic [16:0] MAX_WORDS_C = 17'(MAX_WORDS);

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] addr_r;
    logic [15:0] remaining_r;
    logic [15:0] checksum_r;
    logic        im_we_r;
    logic [15:0] im_addr_r;
    logic [15:0] im_wdata_r;
    logic        idle_like_s;
    logic        start_ok_s;
    logic        count_ok_s;
    logic        hs_s;

    function automatic logic count_legal(input logic [15:0] cnt);
        return (cnt != 16'd0) && ({1'b0, cnt} <= MAX_WORDS_C);
    endfunction

    // Decode of the accepted-start and handshake conditions
    always_comb begin
        idle_like_s = (state_r == IDLE) || (state_r == DONE) || (state_r == ERR);
        start_ok_s  = start && idle_like_s;
        count_ok_s  = count_legal(word_count);
        hs_s        = s_valid && (state_r == LOAD);
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; abort wins over the final handshake so a cancelled
    // load never reports success.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE, DONE, ERR: begin
                if (start_ok_s) begin
                    state_next_s = count_ok_s ? LOAD : ERR;
                end else begin
                    state_next_s = state_r;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_next_s = ERR;
                end else if (hs_s && (remaining_r == 16'd1)) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = LOAD;
                end
            end
            FLUSH:   state_next_s = DONE;
            default: state_next_s = IDLE;
        endcase
    end

    // Status outputs decoded from the current state
    always_comb begin
        s_ready  = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        error    = 1'b0;
        cpu_hold = 1'b1;
        case (state_r)
            LOAD: begin
                s_ready = 1'b1;
                busy    = 1'b1;
            end
            FLUSH: busy = 1'b1;
            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
            end
            ERR:     error = 1'b1;
            default: cpu_hold = 1'b1;
        endcase
    end

    // Datapath: write port is one cycle behind the accepting handshake
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_r      <= BASE_ADDR;
            remaining_r <= 16'd0;
            checksum_r  <= 16'd0;
            im_we_r     <= 1'b0;
            im_addr_r   <= 16'd0;
            im_wdata_r  <= 16'd0;
        end else begin
            im_we_r <= hs_s;
            if (start_ok_s) begin
                checksum_r <= 16'd0;
                if (count_ok_s) begin
                    remaining_r <= word_count;
                    addr_r      <= BASE_ADDR;
                end
            end else if (hs_s) begin
                im_addr_r   <= addr_r;
                im_wdata_r  <= s_data;
                addr_r      <= addr_r + 16'd2;
                checksum_r  <= checksum_r + s_data;
                remaining_r <= remaining_r - 16'd1;
            end
        end
    end

    assign im_we    = im_we_r;
    assign im_addr  = im_addr_r;
    assign im_wdata = im_wdata_r;
    assign checksum = checksum_r;

endmodule

// File: tb/tb_inst_loader.sv
// Directed self-checking bench for inst_loader (BASE_ADDR=0, MAX_WORDS=256).
module tb_inst_loader;

    logic        clk;
    logic        reset;
    logic        start;
    logic [15:0] word_count;
    logic        abort;
    logic        s_valid;
    logic [15:0] s_data;
    logic        s_ready;
    logic        im_we;
    logic [15:0] im_addr;
    logic [15:0] im_wdata;
    logic        cpu_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [15:0] checksum;

    int vectors;
    int miscompares;

    logic [15:0] words [4];

    inst_loader #(.BASE_ADDR(16'h0000), .MAX_WORDS(256)) dut (
        .clk(clk), .reset(reset), .start(start), .word_count(word_count),
        .abort(abort), .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .im_we(im_we), .im_addr(im_addr), .im_wdata(im_wdata),
        .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error),
        .checksum(checksum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [15:0] cnt);
        start      = 1'b1;
        word_count = cnt;
        step();
        start      = 1'b0;
    endtask

    // Streams the four words; with bubble=1 an idle cycle follows each word.
    task automatic stream4(input string tag, input bit bubble);
        for (int i = 0; i < 4; i++) begin
            s_valid = 1'b1;
            s_data  = words[i];
            step();
            chk({tag, "_we"},    {15'd0, im_we}, 16'd1);
            chk({tag, "_addr"},  im_addr, 16'(2 * i));
            chk({tag, "_wdata"}, im_wdata, words[i]);
            s_valid = 1'b0;
            if (bubble && i < 3) begin
                step();
                chk({tag, "_bubble_we"}, {15'd0, im_we}, 16'd0);
            end
        end
        chk({tag, "_flush_busy"},  {15'd0, busy},    16'd1);
        chk({tag, "_flush_ready"}, {15'd0, s_ready}, 16'd0);
        step();
        chk({tag, "_done"},     {15'd0, done},     16'd1);
        chk({tag, "_hold"},     {15'd0, cpu_hold}, 16'd0);
        chk({tag, "_busy"},     {15'd0, busy},     16'd0);
        chk({tag, "_we_after"}, {15'd0, im_we},    16'd0);
        // 1021+5260+0FFE+F025 = 0x162A4, truncated to 16 bits
        chk({tag, "_checksum"}, checksum, 16'h62A4);
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        words[0] = 16'h1021;
        words[1] = 16'h5260;
        words[2] = 16'h0FFE;
        words[3] = 16'hF025;
        reset = 1'b0; start = 1'b0; word_count = 16'd0; abort = 1'b0;
        s_valid = 1'b0; s_data = 16'd0;

        #2;
        chk("rst_hold",     {15'd0, cpu_hold}, 16'd1);
        chk("rst_ready",    {15'd0, s_ready},  16'd0);
        chk("rst_we",       {15'd0, im_we},    16'd0);
        chk("rst_done",     {15'd0, done},     16'd0);
        chk("rst_error",    {15'd0, error},    16'd0);
        chk("rst_checksum", checksum, 16'h0000);
        step();
        reset = 1'b1;
        step();

        // Back-to-back load of four words
        do_start(16'd4);
        chk("t1_busy",  {15'd0, busy},    16'd1);
        chk("t1_ready", {15'd0, s_ready}, 16'd1);
        chk("t1_hold",  {15'd0, cpu_hold}, 16'd1);
        stream4("t1", 1'b0);

        // Restart from DONE with a bubbled stream
        do_start(16'd4);
        chk("t2_done_clr", {15'd0, done}, 16'd0);
        chk("t2_cs_clr",   checksum, 16'h0000);
        stream4("t2", 1'b1);

        // Illegal counts
        do_start(16'd0);
        chk("t3_zero_err",  {15'd0, error}, 16'd1);
        chk("t3_zero_we",   {15'd0, im_we}, 16'd0);
        chk("t3_zero_hold", {15'd0, cpu_hold}, 16'd1);
        chk("t3_zero_done", {15'd0, done}, 16'd0);
        step();
        chk("t3_zero_we2",  {15'd0, im_we}, 16'd0);
        do_start(16'd257);
        chk("t3_big_err",   {15'd0, error}, 16'd1);
        chk("t3_big_ready", {15'd0, s_ready}, 16'd0);
        step();
        chk("t3_big_we",    {15'd0, im_we}, 16'd0);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("t3_abort_err_stays", {15'd0, error}, 16'd1);

        // Abort with the third handshake of an 8-word load
        do_start(16'd8);
        chk("t4_err_clr", {15'd0, error}, 16'd0);
        chk("t4_busy",    {15'd0, busy},  16'd1);
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1;
            s_data  = words[i];
            abort   = (i == 2);
            step();
            chk("t4_we",   {15'd0, im_we}, 16'd1);
            chk("t4_addr", im_addr, 16'(2 * i));
        end
        s_valid = 1'b0;
        abort   = 1'b0;
        chk("t4_err",   {15'd0, error},    16'd1);
        chk("t4_hold",  {15'd0, cpu_hold}, 16'd1);
        chk("t4_ready", {15'd0, s_ready},  16'd0);
        chk("t4_cs",    checksum, 16'h727F);
        step();
        chk("t4_we_after", {15'd0, im_we}, 16'd0);

        // Asynchronous reset two words into a load
        do_start(16'd4);
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1;
            s_data  = words[i];
            step();
        end
        chk("t5_pre_we", {15'd0, im_we}, 16'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_we",    {15'd0, im_we},    16'd0);
        chk("t5_addr",  im_addr, 16'h0000);
        chk("t5_wdata", im_wdata, 16'h0000);
        chk("t5_hold",  {15'd0, cpu_hold}, 16'd1);
        chk("t5_busy",  {15'd0, busy},     16'd0);
        chk("t5_ready", {15'd0, s_ready},  16'd0);
        chk("t5_cs",    checksum, 16'h0000);
        step();
        chk("t5_we_held", {15'd0, im_we}, 16'd0);
        reset   = 1'b1;
        s_valid = 1'b0;
        step();
        chk("t5_idle_we", {15'd0, im_we}, 16'd0);

        // Checksum wrap then reload from DONE
        do_start(16'd2);
        s_valid = 1'b1;
        s_data  = 16'hFFFF;
        step();
        s_data  = 16'h0002;
        step();
        chk("t6_addr", im_addr, 16'h0002);
        s_valid = 1'b0;
        step();
        chk("t6_done", {15'd0, done}, 16'd1);
        chk("t6_cs",   checksum, 16'h0001);
        do_start(16'd1);
        chk("t6_done_clr", {15'd0, done}, 16'd0);
        chk("t6_cs_clr",   checksum, 16'h0000);
        s_valid = 1'b1;
        s_data  = 16'h1234;
        step();
        s_valid = 1'b0;
        chk("t6_re_addr",  im_addr, 16'h0000);
        chk("t6_re_wdata", im_wdata, 16'h1234);
        step();
        chk("t6_re_done", {15'd0, done}, 16'd1);
        chk("t6_re_cs",   checksum, 16'h1234);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
